// File: rtl/pingpong_pkg.sv
// Shared types and helpers for the ping-pong buffer controller.
package pingpong_pkg;

    // Read-side FSM states: IDLE (nothing to drain), DRAIN (emitting reads)
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } rd_state_t;

    // Counter width for a modulo-n counter; a single-state counter still needs one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pingpong_rate_tick.sv
// Read-side rate generator: free-running modulo-TICK_DIV counter that emits a
// registered one-cycle tick on each wrap; clr restarts the period from zero.
module rate_tick #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    import pingpong_pkg::*;

    localparam int               CNT_W   = cnt_width(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Count 0..TICK_DIV-1 and flag the wrap; clear gives a clean period start
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (clr) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CNT_ONE;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/pingpong_ctrl.sv
// Ping-pong buffer controller: producer fills one bank at full rate while the
// other bank is drained at one word per read tick. Banks swap once the write
// bank is full and the read side is idle.
module pingpong_ctrl #(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic                     wr_en,
    output logic                     wr_bank,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic                     rd_en,
    output logic                     rd_bank,
    output logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic                     swap_pulse,
    output logic                     overrun
);
    import pingpong_pkg::*;

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    rd_state_t     state_r,   state_nxt_s;
    logic          wr_full_r, wr_full_nxt_s;
    logic          wr_bank_r, wr_bank_nxt_s;
    logic [AW-1:0] wr_addr_r, wr_addr_nxt_s;
    logic [AW-1:0] rd_addr_r, rd_addr_nxt_s;
    logic          overrun_r, overrun_nxt_s;
    logic          swap_pulse_r;
    logic          wr_en_s;
    logic          rd_en_s;
    logic          swap_s;
    logic          tick_s;

    // The tick period is restarted on every swap so the first read lands
    // exactly TICK_DIV cycles after the swap pulse.
    rate_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_rate_tick (
        .clk_in (clk_in),
        .rst    (rst),
        .clr    (swap_s),
        .tick   (tick_s)
    );

    // Next-state logic: write pointer/full flag, read FSM and swap decision
    always_comb begin
        wr_en_s       = wr_valid & ~wr_full_r;
        swap_s        = wr_full_r & (state_r == IDLE);
        rd_en_s       = tick_s & (state_r == DRAIN);
        state_nxt_s   = state_r;
        wr_full_nxt_s = wr_full_r;
        wr_bank_nxt_s = wr_bank_r;
        wr_addr_nxt_s = wr_addr_r;
        rd_addr_nxt_s = rd_addr_r;
        overrun_nxt_s = overrun_r | (wr_valid & wr_full_r);

        case (state_r)
            IDLE: begin
                if (swap_s) begin
                    state_nxt_s   = DRAIN;
                    wr_bank_nxt_s = ~wr_bank_r;
                    wr_full_nxt_s = 1'b0;
                    rd_addr_nxt_s = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DRAIN: begin
                if (rd_en_s) begin
                    if (rd_addr_r == ADDR_MAX) begin
                        rd_addr_nxt_s = '0;
                        state_nxt_s   = IDLE;
                    end else begin
                        rd_addr_nxt_s = rd_addr_r + ADDR_ONE;
                    end
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        // A write only happens while not full, and a swap only while full,
        // so the two never touch wr_full in the same cycle.
        if (wr_en_s) begin
            if (wr_addr_r == ADDR_MAX) begin
                wr_addr_nxt_s = '0;
                wr_full_nxt_s = 1'b1;
            end else begin
                wr_addr_nxt_s = wr_addr_r + ADDR_ONE;
            end
        end else begin
            wr_addr_nxt_s = wr_addr_r;
        end
    end

    // State registers; reset restarts on bank 0, address 0 with nothing to drain
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            wr_full_r    <= 1'b0;
            wr_bank_r    <= 1'b0;
            wr_addr_r    <= '0;
            rd_addr_r    <= '0;
            overrun_r    <= 1'b0;
            swap_pulse_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            wr_full_r    <= wr_full_nxt_s;
            wr_bank_r    <= wr_bank_nxt_s;
            wr_addr_r    <= wr_addr_nxt_s;
            rd_addr_r    <= rd_addr_nxt_s;
            overrun_r    <= overrun_nxt_s;
            swap_pulse_r <= swap_s;
        end
    end

    assign wr_ready   = ~wr_full_r;
    assign wr_en      = wr_en_s;
    assign wr_bank    = wr_bank_r;
    assign wr_addr    = wr_addr_r;
    assign rd_en      = rd_en_s;
    assign rd_bank    = ~wr_bank_r;
    assign rd_addr    = rd_addr_r;
    assign swap_pulse = swap_pulse_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Directed self-checking bench for pingpong_ctrl. Instance a: DEPTH=4,
// TICK_DIV=3. Instance b: DEPTH=4, TICK_DIV=1. Expected values are
// hand-derived cycle tables; a swap happens on the edge after the cycle in
// which the write bank is full and the read side is idle.
module tb_pingpong_ctrl;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       wr_valid_a, wr_valid_b;
    logic       wr_ready_a, wr_en_a, wr_bank_a, rd_en_a, rd_bank_a, swap_pulse_a, overrun_a;
    logic       wr_ready_b, wr_en_b, wr_bank_b, rd_en_b, rd_bank_b, swap_pulse_b, overrun_b;
    logic [1:0] wr_addr_a, rd_addr_a, wr_addr_b, rd_addr_b;

    int checks = 0;
    int errors = 0;
    int swaps  = 0;

    always #5 clk_in = ~clk_in;

    pingpong_ctrl #(.DEPTH(4), .TICK_DIV(3)) dut_a (
        .clk_in     (clk_in),
        .rst        (rst),
        .wr_valid   (wr_valid_a),
        .wr_ready   (wr_ready_a),
        .wr_en      (wr_en_a),
        .wr_bank    (wr_bank_a),
        .wr_addr    (wr_addr_a),
        .rd_en      (rd_en_a),
        .rd_bank    (rd_bank_a),
        .rd_addr    (rd_addr_a),
        .swap_pulse (swap_pulse_a),
        .overrun    (overrun_a)
    );

    pingpong_ctrl #(.DEPTH(4), .TICK_DIV(1)) dut_b (
        .clk_in     (clk_in),
        .rst        (rst),
        .wr_valid   (wr_valid_b),
        .wr_ready   (wr_ready_b),
        .wr_en      (wr_en_b),
        .wr_bank    (wr_bank_b),
        .wr_addr    (wr_addr_b),
        .rd_en      (rd_en_b),
        .rd_bank    (rd_bank_b),
        .rd_addr    (rd_addr_b),
        .swap_pulse (swap_pulse_b),
        .overrun    (overrun_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, " a wr_bank"},    wr_bank_a,    1'b0);
        chk({tag, " a rd_bank"},    rd_bank_a,    1'b1);
        chk({tag, " a wr_addr"},    wr_addr_a,    2'd0);
        chk({tag, " a rd_addr"},    rd_addr_a,    2'd0);
        chk({tag, " a wr_ready"},   wr_ready_a,   1'b1);
        chk({tag, " a wr_en"},      wr_en_a,      1'b0);
        chk({tag, " a rd_en"},      rd_en_a,      1'b0);
        chk({tag, " a swap_pulse"}, swap_pulse_a, 1'b0);
        chk({tag, " a overrun"},    overrun_a,    1'b0);
        chk({tag, " b wr_bank"},    wr_bank_b,    1'b0);
        chk({tag, " b rd_bank"},    rd_bank_b,    1'b1);
        chk({tag, " b wr_ready"},   wr_ready_b,   1'b1);
        chk({tag, " b rd_en"},      rd_en_b,      1'b0);
        chk({tag, " b swap_pulse"}, swap_pulse_b, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        wr_valid_a = 1'b0;
        wr_valid_b = 1'b0;
        repeat (2) next_cycle();
        #1;
        reset_check("init");
        rst = 1'b0;
        next_cycle();

        // Basic fill, swap, paced drain, then 100 idle cycles
        for (int c = 0; c < 118; c++) begin
            logic rdx;
            wr_valid_a = (c < 4);
            #1;
            rdx = (c == 8) || (c == 11) || (c == 14) || (c == 17);
            chk($sformatf("basic c%0d wr_en", c),      wr_en_a,      (c < 4));
            if (c < 4) chk($sformatf("basic c%0d wr_addr", c), wr_addr_a, c);
            chk($sformatf("basic c%0d wr_ready", c),   wr_ready_a,   (c != 4));
            chk($sformatf("basic c%0d swap_pulse", c), swap_pulse_a, (c == 5));
            chk($sformatf("basic c%0d wr_bank", c),    wr_bank_a,    (c >= 5));
            chk($sformatf("basic c%0d rd_bank", c),    rd_bank_a,    (c < 5));
            chk($sformatf("basic c%0d rd_en", c),      rd_en_a,      rdx);
            if (rdx) chk($sformatf("basic c%0d rd_addr", c), rd_addr_a, (c - 8) / 3);
            chk($sformatf("basic c%0d overrun", c),    overrun_a,    1'b0);
            next_cycle();
        end

        // Backpressure with wr_valid held, then last write coinciding with last read (d31)
        for (int d = 0; d < 41; d++) begin
            logic wv, rdy, rdx, swx, bank;
            int   wa, ra;
            wv   = (d <= 21) || (d == 31) || (d == 34) || (d == 35);
            rdy  = !((d == 4) || (d >= 9 && d <= 18) || (d == 32));
            rdx  = (d == 8) || (d == 11) || (d == 14) || (d == 17) || (d == 22) ||
                   (d == 25) || (d == 28) || (d == 31) || (d == 36) || (d == 39);
            swx  = (d == 5) || (d == 19) || (d == 33);
            bank = (d < 5) || (d >= 19 && d < 33);
            wa   = (d < 4) ? d : (d < 9) ? d - 5 : (d < 22) ? d - 19 : (d == 31) ? 3 : d - 34;
            ra   = (d < 19) ? (d - 8) / 3 : (d < 33) ? (d - 22) / 3 : (d - 36) / 3;
            wr_valid_a = wv;
            #1;
            chk($sformatf("bp d%0d wr_ready", d),   wr_ready_a,   rdy);
            chk($sformatf("bp d%0d wr_en", d),      wr_en_a,      wv && rdy);
            if (wv && rdy) chk($sformatf("bp d%0d wr_addr", d), wr_addr_a, wa);
            chk($sformatf("bp d%0d swap_pulse", d), swap_pulse_a, swx);
            chk($sformatf("bp d%0d wr_bank", d),    wr_bank_a,    bank);
            chk($sformatf("bp d%0d rd_bank", d),    rd_bank_a,    !bank);
            chk($sformatf("bp d%0d rd_en", d),      rd_en_a,      rdx);
            if (rdx) chk($sformatf("bp d%0d rd_addr", d), rd_addr_a, ra);
            chk($sformatf("bp d%0d overrun", d),    overrun_a,    (d >= 5));
            if (d >= 31 && swap_pulse_a === 1'b1) swaps++;
            next_cycle();
        end
        chk("coincide swap count", swaps, 1);

        // Reset asserted mid-drain with a partly filled write bank
        chk("pre-reset overrun", overrun_a, 1'b1);
        chk("pre-reset wr_addr", wr_addr_a, 2'd2);
        rst        = 1'b1;
        wr_valid_a = 1'b0;
        #1;
        reset_check("midrun");
        next_cycle();
        reset_check("hold1");
        next_cycle();
        reset_check("hold2");
        #1;
        rst = 1'b0;
        next_cycle();
        wr_valid_a = 1'b1;
        #1;
        chk("restart wr_en",   wr_en_a,   1'b1);
        chk("restart wr_addr", wr_addr_a, 2'd0);
        chk("restart wr_bank", wr_bank_a, 1'b0);
        chk("restart overrun", overrun_a, 1'b0);
        next_cycle();
        wr_valid_a = 1'b0;
        #1;
        chk("restart wr_addr+1", wr_addr_a, 2'd1);

        // TICK_DIV=1: four consecutive reads right after the swap
        for (int e = 0; e < 12; e++) begin
            logic rdx;
            wr_valid_b = (e < 4);
            #1;
            rdx = (e >= 6) && (e <= 9);
            chk($sformatf("div1 e%0d wr_en", e),      wr_en_b,      (e < 4));
            if (e < 4) chk($sformatf("div1 e%0d wr_addr", e), wr_addr_b, e);
            chk($sformatf("div1 e%0d swap_pulse", e), swap_pulse_b, (e == 5));
            chk($sformatf("div1 e%0d wr_bank", e),    wr_bank_b,    (e >= 5));
            chk($sformatf("div1 e%0d rd_bank", e),    rd_bank_b,    (e < 5));
            chk($sformatf("div1 e%0d rd_en", e),      rd_en_b,      rdx);
            if (rdx) chk($sformatf("div1 e%0d rd_addr", e), rd_addr_b, e - 6);
            chk($sformatf("div1 e%0d overrun", e),    overrun_b,    1'b0);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
